fp_add_result_buf: RTL and testbench

- Downstream stage of the single-precision FP adder.
- Captures each packed result (fp_result, overflow, underflow) plus an issue tag into a small valid/ready FIFO, so a stalled consumer never forces the adder to recompute.
- Accumulates sticky exception flags on retirement, for the CSR/flag logic.
- Sits between the adder's result port and the register-file writeback arbiter.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_add_result_buf_if.sv | 41 ++++
 rtl/fp_result_fifo.sv | 62 ++++++
 rtl/fp_add_result_buf.sv | 97 +++++++++
 tb/tb_fp_add_result_buf.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point types and constants for the FP adder result path.
// Contents:
//   FP32_QNAN     - canonical quiet NaN written in place of any incoming NaN
//   FP32_EXP_ONES - biased exponent value shared by infinities and NaNs
//   fp32_t        - packed IEEE-754 single-precision word
//   fp_flags_t    - exception flags {nv, of, uf}, with nv as the MSB
package fp_pkg;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
  } fp_flags_t;

  localparam fp32_t      FP32_QNAN     = 32'h7FC0_0000;
  localparam logic [7:0] FP32_EXP_ONES = 8'hFF;

endpackage

// File: rtl/fp_add_result_buf_if.sv
// Valid/ready result channel between the FP adder, the result buffer and the
// writeback arbiter.
// Signals:
//   in_valid / in_ready           - adder-side handshake
//   in_result                     - packed FP32 result from the adder
//   in_overflow / in_underflow    - adder exception flags
//   in_tag                        - issue tag travelling with the result
//   out_valid / out_ready         - writeback-side handshake
//   out_result / out_flags / out_tag - head entry {nv, of, uf}
// Modports:
//   slave  - the buffer (consumes in_*, produces out_*)
//   master - the environment (produces in_*, consumes out_*)
interface fp_add_result_buf_if #(
  parameter int TAG_W = 4
);
  import fp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  fp32_t            in_result;
  logic             in_overflow;
  logic             in_underflow;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  fp32_t            out_result;
  logic [2:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_result, in_overflow, in_underflow, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_tag
  );

  modport master (
    output in_valid, in_result, in_overflow, in_underflow, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_tag
  );

endinterface

// File: rtl/fp_result_fifo.sv
// Generic synchronous valid/ready FIFO with an occupancy count.
// Full and empty are derived from the count, so pointer equality is never
// ambiguous. Output data reads zero while empty.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   push_valid/ready/data    - write side; ready = not full (no pop lookahead)
//   pop_valid/ready/data     - read side; data comes straight from rd_ptr
//   count                    - entries held
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
module fp_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 39
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign push_ready = (count != CNT_FULL);
  assign pop_valid  = (count != '0);
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;
  assign pop_data   = pop_valid ? mem[rd_ptr] : '0;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage: not reset; a zero count makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fp_add_result_buf.sv
// Result buffer behind the single-precision FP adder.
// Holds each {result, flags, tag} in a small FIFO so a stalled writeback
// arbiter never forces a recompute, and accumulates sticky exception flags
// as entries retire.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (flushes entries)
//   bus           - fp_add_result_buf_if.slave: adder and writeback channels
//   flags_clr     - clears sticky_flags (flags retiring that cycle survive)
//   sticky_flags  - accumulated {nv, of, uf}
//   occupancy     - entries held
// Optional build macro FP_RESULT_CANON_NAN_EN: NaNs are replaced with the
// canonical quiet NaN at capture and signalling NaNs raise nv. Without it the
// result is stored untouched and nv is always 0.
module fp_add_result_buf
  import fp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  fp_add_result_buf_if.slave       bus,
  input  logic                     flags_clr,
  output logic [2:0]               sticky_flags,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int ENTRY_W = 32 + 3 + TAG_W;

`ifdef FP_RESULT_CANON_NAN_EN
  function automatic logic is_nan(fp32_t v);
    return (v[30:23] == FP32_EXP_ONES) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan(fp32_t v);
    return is_nan(v) && !v[22];
  endfunction

  function automatic fp32_t canon_result(fp32_t v);
    return is_nan(v) ? FP32_QNAN : v;
  endfunction
`endif

  fp32_t               result_p0;
  fp_flags_t           flags_p0;
  logic [ENTRY_W-1:0]  entry_p0;
  logic [ENTRY_W-1:0]  head;
  fp_flags_t           head_flags;
  logic                pop;

  // Capture stage: shape the incoming result and flags into one entry.
`ifdef FP_RESULT_CANON_NAN_EN
  assign result_p0 = canon_result(bus.in_result);
  assign flags_p0  = '{nv: is_snan(bus.in_result),
                       of: bus.in_overflow,
                       uf: bus.in_underflow};
`else
  assign result_p0 = bus.in_result;
  assign flags_p0  = '{nv: 1'b0,
                       of: bus.in_overflow,
                       uf: bus.in_underflow};
`endif
  assign entry_p0 = {result_p0, flags_p0, bus.in_tag};

  // Buffer stage.
  fp_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_data  (entry_p0),
    .pop_valid  (bus.out_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (head),
    .count      (occupancy)
  );

  assign bus.out_result = head[ENTRY_W-1 -: 32];
  assign head_flags     = head[TAG_W +: 3];
  assign bus.out_flags  = head_flags;
  assign bus.out_tag    = head[TAG_W-1:0];
  assign pop            = bus.out_valid & bus.out_ready;

  // Retire stage: flags retiring in the same cycle as a clear are kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= 3'b000;
    end else begin
      sticky_flags <= (flags_clr ? 3'b000 : sticky_flags)
                    | (pop ? head_flags : 3'b000);
    end
  end

endmodule

// File: tb/tb_fp_add_result_buf.sv
module tb_fp_add_result_buf;
  import fp_pkg::*;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int EW    = 32 + 3 + TAG_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flags_clr;
  logic [2:0]             sticky_flags;
  logic [$clog2(DEPTH):0] occupancy;

  fp_add_result_buf_if #(.TAG_W(TAG_W)) bus ();

  fp_add_result_buf #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          pops     = 0;
  logic [EW-1:0] q[$];
  logic [2:0]  sticky_m = 3'b000;
  bit          model_ok = 1'b0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // Reference capture: what the buffer should store for a given input.
  function automatic logic [EW-1:0] expect_entry(fp32_t r, logic of, logic uf,
                                                 logic [TAG_W-1:0] t);
    fp32_t res = r;
    logic  nv  = 1'b0;
`ifdef FP_RESULT_CANON_NAN_EN
    if (r[30:23] == 8'hFF && r[22:0] != 23'd0) begin
      nv  = ~r[22];
      res = 32'h7FC0_0000;
    end
`endif
    return {res, nv, of, uf, t};
  endfunction

  // One clock: check state at the negedge, then advance the model at posedge.
  task automatic tick();
    logic          push_m;
    logic          pop_m;
    logic [EW-1:0] ent;
    logic [EW-1:0] hd;
    @(negedge clk);
    push_m = bus.in_valid && (q.size() != DEPTH);
    pop_m  = bus.out_ready && (q.size() != 0);
    ent    = expect_entry(bus.in_result, bus.in_overflow, bus.in_underflow, bus.in_tag);
    if (model_ok) begin
      chk("in_ready",  64'(bus.in_ready),  64'(q.size() != DEPTH));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("occupancy", 64'(occupancy),     64'(q.size()));
      chk("sticky",    64'(sticky_flags),  64'(sticky_m));
      hd = (q.size() != 0) ? q[0] : '0;
      chk("head_result", 64'(bus.out_result), 64'(hd[EW-1 -: 32]));
      chk("head_flags",  64'(bus.out_flags),  64'(hd[TAG_W +: 3]));
      chk("head_tag",    64'(bus.out_tag),    64'(hd[TAG_W-1:0]));
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      sticky_m = 3'b000;
      model_ok = 1'b1;
    end else begin
      sticky_m = (flags_clr ? 3'b000 : sticky_m) | (pop_m ? q[0][TAG_W +: 3] : 3'b000);
      if (pop_m) begin
        void'(q.pop_front());
        pops++;
      end
      if (push_m) q.push_back(ent);
    end
    #1;
  endtask

  task automatic drive(logic v, fp32_t r, logic of, logic uf, logic [TAG_W-1:0] t);
    bus.in_valid     = v;
    bus.in_result    = r;
    bus.in_overflow  = of;
    bus.in_underflow = uf;
    bus.in_tag       = t;
  endtask

  initial begin
    int p0;
    rst           = 1'b1;
    flags_clr     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_occ",      64'(occupancy),    64'd0);

    // Single push with consumer ready.
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0014_0000, 1'b0, 1'b0, 4'd3);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0);
    chk("single_valid",  64'(bus.out_valid),  64'd1);
    chk("single_result", 64'(bus.out_result), 64'h0014_0000);
    chk("single_tag",    64'(bus.out_tag),    64'd3);
    tick();
    chk("single_occ",    64'(occupancy),      64'd0);
    chk("single_sticky", 64'(sticky_flags),   64'd0);

    // Backpressure: fill, hold the third, then drain.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h3F80_0000, 1'b0, 1'b0, 4'd1);
    tick();
    drive(1'b1, 32'h4000_0000, 1'b0, 1'b0, 4'd2);
    tick();
    chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'h4040_0000, 1'b0, 1'b0, 4'd3);
    tick();
    chk("bp_hold_head", 64'(bus.out_result), 64'h3F80_0000);
    bus.out_ready = 1'b1;
    tick();
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0);
    chk("bp_last_head", 64'(bus.out_result), 64'h4040_0000);
    tick();
    chk("bp_drained", 64'(occupancy), 64'd0);

    // Sticky flag accumulation and clear.
    drive(1'b1, 32'h7F80_0000, 1'b1, 1'b0, 4'd1);
    tick();
    drive(1'b1, 32'h0000_0001, 1'b0, 1'b1, 4'd2);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0);
    tick();
    chk("sticky_acc", 64'(sticky_flags), 64'b011);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    chk("sticky_clr", 64'(sticky_flags), 64'b000);
    drive(1'b1, 32'h3F80_0000, 1'b0, 1'b1, 4'd3);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0);
    tick();
    chk("sticky_uf", 64'(sticky_flags), 64'b001);
    drive(1'b1, 32'h4000_0000, 1'b1, 1'b0, 4'd4);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    chk("sticky_clr_pop", 64'(sticky_flags), 64'b010);

    // Full-rate streaming with wrapping pointers.
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h4100_0000 + 32'(i), 1'b0, 1'b0, TAG_W'(i));
      tick();
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    chk("stream_pops", 64'(pops - p0), 64'd19);
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0);
    tick();

    // Reset with two entries held and the consumer ready.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h4200_0000, 1'b1, 1'b0, 4'd7);
    tick();
    drive(1'b1, 32'h4210_0000, 1'b0, 1'b1, 4'd8);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0);
    p0 = pops;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid",  64'(bus.out_valid), 64'd0);
    chk("rst_mid_occ",    64'(occupancy),     64'd0);
    chk("rst_mid_sticky", 64'(sticky_flags),  64'd0);
    tick();
    chk("rst_mid_pops",   64'(pops - p0),     64'd0);

    // NaN handling.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h7FA0_0001, 1'b0, 1'b0, 4'd5);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0);
`ifdef FP_RESULT_CANON_NAN_EN
    chk("snan_result", 64'(bus.out_result), 64'h7FC0_0000);
    chk("snan_flags",  64'(bus.out_flags),  64'b100);
`else
    chk("snan_result", 64'(bus.out_result), 64'h7FA0_0001);
    chk("snan_flags",  64'(bus.out_flags),  64'b000);
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hFFC0_0005, 1'b0, 1'b0, 4'd6);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, '0);
`ifdef FP_RESULT_CANON_NAN_EN
    chk("qnan_result", 64'(bus.out_result), 64'h7FC0_0000);
`else
    chk("qnan_result", 64'(bus.out_result), 64'hFFC0_0005);
`endif
    chk("qnan_flags", 64'(bus.out_flags), 64'b000);
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
